// File: rtl/riscv_v_pkg.sv
// Shared types for the vector permutation write-back stage: queue entry layout,
// controller state encoding and a saturating counter helper.
package riscv_v_pkg;

    localparam int RISCV_V_DATA_WIDTH     = 128;
    localparam int RISCV_V_NUM_BYTES_DATA = RISCV_V_DATA_WIDTH / 8;
    localparam int RISCV_V_VEC_RES_WIDTH  = RISCV_V_DATA_WIDTH + RISCV_V_NUM_BYTES_DATA;
    localparam int RISCV_V_INT_WIDTH      = 32;
    localparam int RISCV_V_REG_ADDR_WIDTH = 5;
    localparam int RISCV_V_STALL_CNT_W    = 16;

    // Destination kind of a queued permutation result
    typedef enum logic {
        WB_TYPE_I2V = 1'b0,
        WB_TYPE_V2I = 1'b1
    } wb_type_e;

    // One queued result; vec_data keeps the per-byte valid bits in its low slice
    typedef struct packed {
        wb_type_e                          typ;
        logic [RISCV_V_REG_ADDR_WIDTH-1:0] rd;
        logic [RISCV_V_REG_ADDR_WIDTH-1:0] vd;
        logic [RISCV_V_INT_WIDTH-1:0]      int_data;
        logic [RISCV_V_VEC_RES_WIDTH-1:0]  vec_data;
    } wb_entry_t;

    // Write-back controller states
    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_STALL = 2'd2
    } wb_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [RISCV_V_STALL_CNT_W-1:0] sat_inc_cnt(
        input logic [RISCV_V_STALL_CNT_W-1:0] v
    );
        return (&v) ? v : v + RISCV_V_STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/riscv_v_permutation_wb_if.sv
// Bundle of the result handshake and register-file write ports of the
// permutation write-back stage.
interface riscv_v_permutation_wb_if;
    import riscv_v_pkg::*;

    logic                              flush_i;
    logic                              valid_i;
    logic                              ready_o;
    logic                              is_i2v_i;
    logic                              is_v2i_i;
    logic [RISCV_V_REG_ADDR_WIDTH-1:0] rd_addr_i;
    logic [RISCV_V_REG_ADDR_WIDTH-1:0] vd_addr_i;
    logic [RISCV_V_INT_WIDTH-1:0]      integer_data_i;
    logic [RISCV_V_VEC_RES_WIDTH-1:0]  vector_data_i;
    logic                              int_wr_en_o;
    logic                              int_wr_ready_i;
    logic [RISCV_V_REG_ADDR_WIDTH-1:0] int_wr_addr_o;
    logic [RISCV_V_INT_WIDTH-1:0]      int_wr_data_o;
    logic                              vec_wr_en_o;
    logic [RISCV_V_REG_ADDR_WIDTH-1:0] vec_wr_addr_o;
    logic [RISCV_V_DATA_WIDTH-1:0]     vec_wr_data_o;
    logic [RISCV_V_NUM_BYTES_DATA-1:0] vec_wr_byte_en_o;
    logic                              err_o;
    logic [RISCV_V_STALL_CNT_W-1:0]    stall_cnt_o;

    // Write-back stage side
    modport slave (
        input  flush_i, valid_i, is_i2v_i, is_v2i_i, rd_addr_i, vd_addr_i,
               integer_data_i, vector_data_i, int_wr_ready_i,
        output ready_o, int_wr_en_o, int_wr_addr_o, int_wr_data_o,
               vec_wr_en_o, vec_wr_addr_o, vec_wr_data_o, vec_wr_byte_en_o,
               err_o, stall_cnt_o
    );

    // Permutation ALU / register file side
    modport master (
        output flush_i, valid_i, is_i2v_i, is_v2i_i, rd_addr_i, vd_addr_i,
               integer_data_i, vector_data_i, int_wr_ready_i,
        input  ready_o, int_wr_en_o, int_wr_addr_o, int_wr_data_o,
               vec_wr_en_o, vec_wr_addr_o, vec_wr_data_o, vec_wr_byte_en_o,
               err_o, stall_cnt_o
    );

endinterface

// File: rtl/riscv_v_wb_fifo.sv
// Result queue for the permutation write-back stage. DEPTH must be a power of
// two so the pointers wrap naturally. Storage is not reset; only pointers and
// the occupancy count are.
module riscv_v_wb_fifo
    import riscv_v_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  wb_entry_t        entry_i,
    output wb_entry_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointer and occupancy update; flush wins over any push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/riscv_v_permutation_wb.sv
// Permutation write-back stage: queues integer-to-vector and vector-to-integer
// results and drains them, one per cycle, to the vector or scalar register
// file. The vector port always accepts; the scalar port may stall the head.
module riscv_v_permutation_wb
    import riscv_v_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic                      clk,
    input logic                      rst,
    riscv_v_permutation_wb_if.slave  wb
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t                       entry_in;
    wb_entry_t                       head;
    logic [CNT_W-1:0]                count;
    logic [CNT_W-1:0]                count_next;
    logic                            ready;
    logic                            accept;
    logic                            push;
    logic                            pop;
    logic                            both_set;

    wb_state_e                       state_q, state_d;
    logic                            err_q, err_d;
    logic [RISCV_V_STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic                            int_wr_en;
    logic [RISCV_V_REG_ADDR_WIDTH-1:0] int_wr_addr;
    logic [RISCV_V_INT_WIDTH-1:0]    int_wr_data;
    logic                            vec_wr_en;
    logic [RISCV_V_REG_ADDR_WIDTH-1:0] vec_wr_addr;
    logic [RISCV_V_DATA_WIDTH-1:0]   vec_wr_data;
    logic [RISCV_V_NUM_BYTES_DATA-1:0] vec_wr_byte_en;

    assign ready = (count < CNT_W'(DEPTH));

    // Upstream handshake: classify the incoming result and build its entry
    always_comb begin
        accept            = wb.valid_i && ready;
        push              = accept && (wb.is_i2v_i ^ wb.is_v2i_i) && !wb.flush_i;
        both_set          = accept && wb.is_i2v_i && wb.is_v2i_i;
        entry_in.typ      = wb.is_v2i_i ? WB_TYPE_V2I : WB_TYPE_I2V;
        entry_in.rd       = wb.rd_addr_i;
        entry_in.vd       = wb.vd_addr_i;
        entry_in.int_data = wb.integer_data_i;
        entry_in.vec_data = wb.vector_data_i;
    end

    riscv_v_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (wb.flush_i),
        .push_i       (push),
        .pop_i        (pop),
        .entry_i      (entry_in),
        .head_o       (head),
        .count_o      (count),
        .count_next_o (count_next)
    );

    // Write ports driven from the head entry, plus next-state selection
    always_comb begin
        int_wr_en      = 1'b0;
        int_wr_addr    = '0;
        int_wr_data    = '0;
        vec_wr_en      = 1'b0;
        vec_wr_addr    = '0;
        vec_wr_data    = '0;
        vec_wr_byte_en = '0;
        pop            = 1'b0;
        state_d        = state_q;

        if (state_q != WB_IDLE) begin
            if (head.typ == WB_TYPE_V2I) begin
                int_wr_en   = 1'b1;
                int_wr_addr = head.rd;
                int_wr_data = head.int_data;
                pop         = wb.int_wr_ready_i;
            end else begin
                vec_wr_en      = 1'b1;
                vec_wr_addr    = head.vd;
                vec_wr_data    = head.vec_data[RISCV_V_VEC_RES_WIDTH-1:RISCV_V_NUM_BYTES_DATA];
                vec_wr_byte_en = head.vec_data[RISCV_V_NUM_BYTES_DATA-1:0];
                pop            = 1'b1;
            end
        end

        // A v2i head that was offered but not granted keeps the port held in STALL
        if (wb.flush_i || (count_next == '0)) begin
            state_d = WB_IDLE;
        end else if (int_wr_en && !wb.int_wr_ready_i) begin
            state_d = WB_STALL;
        end else begin
            state_d = WB_WRITE;
        end
    end

    // Sticky error flag and saturating stall-cycle counter
    always_comb begin
        err_d       = err_q | both_set;
        stall_cnt_d = (state_q == WB_STALL) ? sat_inc_cnt(stall_cnt_q) : stall_cnt_q;
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WB_IDLE;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wb.ready_o          = ready;
    assign wb.int_wr_en_o      = int_wr_en;
    assign wb.int_wr_addr_o    = int_wr_addr;
    assign wb.int_wr_data_o    = int_wr_data;
    assign wb.vec_wr_en_o      = vec_wr_en;
    assign wb.vec_wr_addr_o    = vec_wr_addr;
    assign wb.vec_wr_data_o    = vec_wr_data;
    assign wb.vec_wr_byte_en_o = vec_wr_byte_en;
    assign wb.err_o            = err_q;
    assign wb.stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_riscv_v_permutation_wb.sv
// Self-checking bench for the permutation write-back stage: a vector table,
// hand-written multi-cycle sequences and a randomized run against a queue model.
module tb_riscv_v_permutation_wb;
    import riscv_v_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    riscv_v_permutation_wb_if bus ();

    riscv_v_permutation_wb #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    typedef struct {
        string        name;
        logic         i2v;
        logic         v2i;
        logic [4:0]   rd;
        logic [4:0]   vd;
        logic [31:0]  id;
        logic [143:0] vdat;
        logic         exp_int;
        logic         exp_vec;
        logic [4:0]   exp_addr;
        logic [31:0]  exp_id;
        logic [127:0] exp_vd;
        logic [15:0]  exp_be;
    } vec_t;

    typedef struct {
        logic         v2i;
        logic [4:0]   addr;
        logic [31:0]  id;
        logic [127:0] vd;
        logic [15:0]  be;
    } mentry_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic i2v, input logic v2i,
                          input logic [4:0] rd, input logic [4:0] vd,
                          input logic [31:0] id, input logic [143:0] vdat);
        bus.valid_i        = v;
        bus.is_i2v_i       = i2v;
        bus.is_v2i_i       = v2i;
        bus.rd_addr_i      = rd;
        bus.vd_addr_i      = vd;
        bus.integer_data_i = id;
        bus.vector_data_i  = vdat;
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 144'd0);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".int_en"}, bus.int_wr_en_o, 1'b0);
        chk({name, ".vec_en"}, bus.vec_wr_en_o, 1'b0);
        chk({name, ".int_data"}, bus.int_wr_data_o, 32'd0);
        chk({name, ".vec_data"}, bus.vec_wr_data_o, 128'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        idle_in();
        bus.flush_i        = 1'b0;
        bus.int_wr_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({name, ".ready"}, bus.ready_o, 1'b1);
        chk({name, ".err"}, bus.err_o, 1'b0);
        chk({name, ".stall_cnt"}, bus.stall_cnt_o, 16'd0);
        chk_quiet(name);
    endtask

    // One v2i push with the given register and data
    task automatic push_v2i(input logic [4:0] rd, input logic [31:0] id);
        set_in(1'b1, 1'b0, 1'b1, rd, 5'd0, id, 144'd0);
    endtask

    task automatic run_table();
        vec_t tbl[5];
        tbl[0] = '{"i2v_a5", 1'b1, 1'b0, 5'd0, 5'd3, 32'd0,
                   {{16{8'hA5}}, 16'hFFFF},
                   1'b0, 1'b1, 5'd3, 32'd0, {16{8'hA5}}, 16'hFFFF};
        tbl[1] = '{"i2v_part", 1'b1, 1'b0, 5'd4, 5'd31, 32'hDEAD,
                   {128'h0123456789ABCDEF_FEDCBA9876543210, 16'h00F0},
                   1'b0, 1'b1, 5'd31, 32'd0, 128'h0123456789ABCDEF_FEDCBA9876543210, 16'h00F0};
        tbl[2] = '{"v2i_neg", 1'b0, 1'b1, 5'd7, 5'd2, 32'hFFFFFF80,
                   {128'h1, 16'h1},
                   1'b1, 1'b0, 5'd7, 32'hFFFFFF80, 128'd0, 16'd0};
        tbl[3] = '{"v2i_x0", 1'b0, 1'b1, 5'd0, 5'd9, 32'h12345678,
                   144'd0,
                   1'b1, 1'b0, 5'd0, 32'h12345678, 128'd0, 16'd0};
        tbl[4] = '{"none_drop", 1'b0, 1'b0, 5'd5, 5'd6, 32'h55,
                   {128'h77, 16'hFFFF},
                   1'b0, 1'b0, 5'd0, 32'd0, 128'd0, 16'd0};

        do_reset("tbl_reset");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.int_wr_ready_i = 1'b1;
            set_in(1'b1, tbl[i].i2v, tbl[i].v2i, tbl[i].rd, tbl[i].vd, tbl[i].id, tbl[i].vdat);
            #1;
            chk({tbl[i].name, ".ready"}, bus.ready_o, 1'b1);
            chk_quiet({tbl[i].name, ".same_cycle"});
            @(negedge clk);
            idle_in();
            #1;
            chk({tbl[i].name, ".int_en"}, bus.int_wr_en_o, tbl[i].exp_int);
            chk({tbl[i].name, ".vec_en"}, bus.vec_wr_en_o, tbl[i].exp_vec);
            chk({tbl[i].name, ".int_addr"}, bus.int_wr_addr_o, tbl[i].exp_int ? tbl[i].exp_addr : 5'd0);
            chk({tbl[i].name, ".int_data"}, bus.int_wr_data_o, tbl[i].exp_id);
            chk({tbl[i].name, ".vec_addr"}, bus.vec_wr_addr_o, tbl[i].exp_vec ? tbl[i].exp_addr : 5'd0);
            chk({tbl[i].name, ".vec_data"}, bus.vec_wr_data_o, tbl[i].exp_vd);
            chk({tbl[i].name, ".byte_en"}, bus.vec_wr_byte_en_o, tbl[i].exp_be);
            @(negedge clk);
            #1;
            chk_quiet({tbl[i].name, ".after"});
            chk({tbl[i].name, ".err"}, bus.err_o, 1'b0);
        end
    endtask

    task automatic seq_stall();
        do_reset("stall_reset");
        @(negedge clk);
        push_v2i(5'd7, 32'hFFFFFF80);
        #1;
        chk("stall.push_quiet", bus.int_wr_en_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle_in();
            bus.int_wr_ready_i = (k == 3);
            #1;
            chk($sformatf("stall.en%0d", k), bus.int_wr_en_o, 1'b1);
            chk($sformatf("stall.addr%0d", k), bus.int_wr_addr_o, 5'd7);
            chk($sformatf("stall.data%0d", k), bus.int_wr_data_o, 32'hFFFFFF80);
            chk($sformatf("stall.vec%0d", k), bus.vec_wr_en_o, 1'b0);
        end
        @(negedge clk);
        bus.int_wr_ready_i = 1'b0;
        #1;
        chk("stall.popped", bus.int_wr_en_o, 1'b0);
        chk("stall.cnt", bus.stall_cnt_o, 16'd3);
        @(negedge clk);
        #1;
        chk("stall.cnt_hold", bus.stall_cnt_o, 16'd3);
    endtask

    task automatic seq_full();
        do_reset("full_reset");
        @(negedge clk);
        push_v2i(5'd1, 32'h11);
        #1;
        chk("full.ready0", bus.ready_o, 1'b1);
        @(negedge clk);
        push_v2i(5'd2, 32'h22);
        #1;
        chk("full.ready1", bus.ready_o, 1'b1);
        chk("full.head1", bus.int_wr_addr_o, 5'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            push_v2i(5'd3, 32'h33);
            #1;
            chk($sformatf("full.ready_lo%0d", k), bus.ready_o, 1'b0);
            chk($sformatf("full.hold%0d", k), bus.int_wr_data_o, 32'h11);
        end
        @(negedge clk);
        bus.int_wr_ready_i = 1'b1;
        #1;
        chk("full.w1_addr", bus.int_wr_addr_o, 5'd1);
        chk("full.ready_still_lo", bus.ready_o, 1'b0);
        @(negedge clk);
        #1;
        chk("full.ready_back", bus.ready_o, 1'b1);
        chk("full.w2_addr", bus.int_wr_addr_o, 5'd2);
        chk("full.w2_data", bus.int_wr_data_o, 32'h22);
        @(negedge clk);
        idle_in();
        #1;
        chk("full.w3_en", bus.int_wr_en_o, 1'b1);
        chk("full.w3_addr", bus.int_wr_addr_o, 5'd3);
        chk("full.w3_data", bus.int_wr_data_o, 32'h33);
        @(negedge clk);
        #1;
        chk_quiet("full.drained");
        chk("full.ready_end", bus.ready_o, 1'b1);
    endtask

    task automatic seq_err();
        do_reset("err_reset");
        @(negedge clk);
        bus.int_wr_ready_i = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 32'hABCD, {128'hFF, 16'hFFFF});
        #1;
        chk("err.before", bus.err_o, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle_in();
            #1;
            chk($sformatf("err.sticky%0d", k), bus.err_o, 1'b1);
            chk_quiet($sformatf("err.nowrite%0d", k));
            chk($sformatf("err.ready%0d", k), bus.ready_o, 1'b1);
        end
        do_reset("err_cleared");
    endtask

    task automatic seq_flush();
        do_reset("flush_reset");
        @(negedge clk);
        push_v2i(5'd4, 32'h44);
        @(negedge clk);
        push_v2i(5'd5, 32'h55);
        @(negedge clk);
        idle_in();
        #1;
        chk("flush.ready_full", bus.ready_o, 1'b0);
        chk("flush.stall_addr", bus.int_wr_addr_o, 5'd4);
        @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        chk("flush.en_in_flush", bus.int_wr_en_o, 1'b1);
        @(negedge clk);
        bus.flush_i        = 1'b0;
        bus.int_wr_ready_i = 1'b1;
        #1;
        chk("flush.ready", bus.ready_o, 1'b1);
        chk_quiet("flush.idle");
        chk("flush.stall_cnt", bus.stall_cnt_o, 16'd2);
        @(negedge clk);
        #1;
        chk_quiet("flush.idle2");
        chk("flush.err", bus.err_o, 1'b0);
    endtask

    task automatic seq_rst_stall();
        do_reset("rst_reset");
        @(negedge clk);
        push_v2i(5'd6, 32'h66);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle_in();
        end
        #1;
        chk("rst.in_stall", bus.int_wr_en_o, 1'b1);
        chk("rst.cnt_before", bus.stall_cnt_o, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.ready", bus.ready_o, 1'b1);
        chk("rst.stall_cnt", bus.stall_cnt_o, 16'd0);
        chk("rst.err", bus.err_o, 1'b0);
        chk_quiet("rst.quiet");
        @(negedge clk);
        bus.int_wr_ready_i = 1'b1;
        #1;
        chk_quiet("rst.no_more");
    endtask

    task automatic run_random();
        mentry_t mq[$];
        mentry_t e;
        logic    v, i2v, v2i, rdy, fl, acc, popm, in_stall, err_m;
        int      t, stall_m;
        logic [143:0] vdat;
        logic [4:0]   rd, vd;
        logic [31:0]  id;

        do_reset("rand_reset");
        in_stall = 1'b0;
        err_m    = 1'b0;
        stall_m  = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            v    = ($urandom_range(0, 9) < 7);
            t    = $urandom_range(0, 9);
            i2v  = (t == 1) || (t >= 2 && t <= 5);
            v2i  = (t == 1) || (t >= 6);
            rdy  = $urandom_range(0, 1) == 1;
            fl   = ($urandom_range(0, 24) == 0);
            rd   = 5'($urandom);
            vd   = 5'($urandom);
            id   = $urandom;
            vdat = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            set_in(v, i2v, v2i, rd, vd, id, vdat);
            bus.int_wr_ready_i = rdy;
            bus.flush_i        = fl;
            #1;
            chk("rand.ready", bus.ready_o, mq.size() < DEPTH);
            chk("rand.err", bus.err_o, err_m);
            chk("rand.stall_cnt", bus.stall_cnt_o, 16'(stall_m));
            chk("rand.excl", bus.int_wr_en_o && bus.vec_wr_en_o, 1'b0);
            if (mq.size() > 0) e = mq[0];
            else e = '{1'b0, 5'd0, 32'd0, 128'd0, 16'd0};
            chk("rand.int_en", bus.int_wr_en_o, (mq.size() > 0) && e.v2i);
            chk("rand.vec_en", bus.vec_wr_en_o, (mq.size() > 0) && !e.v2i);
            chk("rand.int_addr", bus.int_wr_addr_o, (mq.size() > 0 && e.v2i) ? e.addr : 5'd0);
            chk("rand.int_data", bus.int_wr_data_o, (mq.size() > 0 && e.v2i) ? e.id : 32'd0);
            chk("rand.vec_addr", bus.vec_wr_addr_o, (mq.size() > 0 && !e.v2i) ? e.addr : 5'd0);
            chk("rand.vec_data", bus.vec_wr_data_o, (mq.size() > 0 && !e.v2i) ? e.vd : 128'd0);
            chk("rand.byte_en", bus.vec_wr_byte_en_o, (mq.size() > 0 && !e.v2i) ? e.be : 16'd0);
            @(posedge clk);
            acc  = v && (mq.size() < DEPTH);
            popm = (mq.size() > 0) && (!e.v2i || rdy);
            if (in_stall && stall_m < 16'hFFFF) stall_m++;
            if (acc && i2v && v2i) err_m = 1'b1;
            in_stall = !fl && (mq.size() > 0) && e.v2i && !rdy;
            if (fl) begin
                mq.delete();
            end else begin
                if (popm) void'(mq.pop_front());
                if (acc && (i2v ^ v2i)) begin
                    if (v2i) mq.push_back('{1'b1, rd, id, 128'd0, 16'd0});
                    else     mq.push_back('{1'b0, vd, 32'd0, vdat[143:16], vdat[15:0]});
                end
            end
        end
        @(negedge clk);
        bus.flush_i = 1'b0;
    endtask

    initial begin
        bus.flush_i        = 1'b0;
        bus.int_wr_ready_i = 1'b0;
        idle_in();
        run_table();
        seq_stall();
        seq_full();
        seq_err();
        seq_flush();
        seq_rst_stall();
        run_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 1000000", $time);
        $fatal(1);
    end

endmodule

// File: doc/riscv_v_permutation_wb.md
RISCV_V_PERMUTATION_WB -- requirements
Module: riscv_v_permutation_wb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, using the codebase port names clk and rst.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the result-queue entry count (power of two, at least 2).
REQ-003 The ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  discard all queued results
- valid_i  in  1  permutation result present
- ready_o  out  1  stage can accept a result
- is_i2v_i  in  1  result is integer-to-vector
- is_v2i_i  in  1  result is vector-to-integer
- rd_addr_i  in  5  scalar destination register
- vd_addr_i  in  5  vector destination register
- integer_data_i  in  32  permutation ALU integer result
- vector_data_i  in  144  permutation ALU vector result: [143:16] data, [15:0] per-byte valid
- int_wr_en_o  out  1  scalar register file write request
- int_wr_ready_i  in  1  scalar write port grant
- int_wr_addr_o  out  5  scalar write address
- int_wr_data_o  out  32  scalar write data
- vec_wr_en_o  out  1  vector register file write; always accepted
- vec_wr_addr_o  out  5  vector write address
- vec_wr_data_o  out  128  vector write data
- vec_wr_byte_en_o  out  16  vector byte enables, taken from the valid bits [15:0]
- err_o  out  1  sticky flag: a result with both is_i2v_i and is_v2i_i set was received
- stall_cnt_o  out  16  saturating count of cycles spent in STALL

Function
REQ-004 ready_o SHALL equal (count < DEPTH); there is no same-cycle bypass when the queue is full.
REQ-005 A result SHALL be enqueued when valid_i && ready_o && (is_i2v_i ^ is_v2i_i) && !flush_i.
REQ-006 When valid_i && ready_o and neither is_i2v_i nor is_v2i_i is set, the result SHALL be accepted and dropped, with no queue or write effect.
REQ-007 When valid_i && ready_o and both is_i2v_i and is_v2i_i are set, the result SHALL be dropped and err_o SHALL be set, remaining set until rst.
REQ-008 Write outputs SHALL be driven combinationally from the head entry only, so a result enqueued in cycle N is written no earlier than cycle N+1.
REQ-009 The controller SHALL be an FSM with the states IDLE (queue empty), WRITE (head present and writable) and STALL (head is v2i and int_wr_ready_i=0).
REQ-010 In IDLE, all write enables SHALL be 0.
REQ-011 In WRITE with an i2v head, vec_wr_en_o SHALL be 1 for exactly one cycle and the head SHALL be popped in that cycle.
REQ-012 In WRITE with a v2i head, int_wr_en_o SHALL be 1 and the head SHALL be popped in the cycle int_wr_ready_i=1; otherwise the FSM SHALL go to STALL.
REQ-013 In STALL, int_wr_en_o, int_wr_addr_o and int_wr_data_o SHALL be held stable until int_wr_ready_i=1; that cycle SHALL pop the head and leave STALL.
REQ-014 int_wr_en_o and vec_wr_en_o SHALL never both be 1 in the same cycle.
REQ-015 Simultaneous push and pop SHALL keep count unchanged, and the read and write pointers SHALL wrap modulo DEPTH.
REQ-016 When not asserted, write-data outputs SHALL be 0.
REQ-017 flush_i SHALL clear the pointers and count, force IDLE, and block enqueue in the same cycle; a write enable already asserted in the flush cycle is still valid, and err_o and stall_cnt_o are unaffected.
REQ-018 stall_cnt_o SHALL increment once per cycle spent in STALL and saturate at 16'hFFFF.

Reset
REQ-019 On rst, the block SHALL set count, pointers, err_o and stall_cnt_o to 0 and the FSM to IDLE, giving ready_o=1 and all write enables 0 in the following cycle.
REQ-020 A rst asserted mid-operation, including in STALL, SHALL discard all queued results with no further writes.
REQ-021 Queue storage SHALL need no reset.

Structure
REQ-022 The entry struct (type, rd, vd, 32-bit int data, 144-bit vector data) and the FSM state enum SHALL be defined in riscv_v_pkg, sized from RISCV_V_DATA_WIDTH and RISCV_V_NUM_BYTES_DATA.
REQ-023 Queue storage and pointers SHALL be in the sub-module riscv_v_wb_fifo, with the FSM and counters in the top module.

Verification
REQ-024 The bench SHALL cover: i2v push with vd=3, data=128'hA5..A5, valid=16'hFFFF -> next cycle vec_wr_en_o=1, addr=3, byte_en=16'hFFFF, for one cycle.
REQ-025 The bench SHALL cover: v2i push with rd=7, data=32'hFFFFFF80, int_wr_ready_i low for 3 cycles -> int_wr_en_o held for 4 cycles with stable data, stall_cnt_o=3, then pop.
REQ-026 The bench SHALL cover: 3 back-to-back pushes with DEPTH=2 and the port stalled -> ready_o=0 after the 2nd push, the 3rd result is held upstream, and writes occur in order.
REQ-027 The bench SHALL cover: a push with is_i2v_i=is_v2i_i=1 -> no write, and err_o=1 persisting until rst.
REQ-028 The bench SHALL cover: flush_i asserted while in STALL with 2 entries queued -> next cycle IDLE, ready_o=1, no further writes.
REQ-029 The bench SHALL cover: rst asserted mid-STALL -> next cycle all outputs at reset values and stall_cnt_o=0.
